// File: rtl/taxi_axi_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | taxi_axi_sched_pkg : shared types for the AXI write-path scheduler          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package taxi_axi_sched_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } aw_state_t;

endpackage

`default_nettype wire

// File: rtl/taxi_axi_wr_sched_fifo.sv
// +----------------------------------------------------------------------------+
// | taxi_axi_wr_sched_fifo : small index FIFO recording requester grant order   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module taxi_axi_wr_sched_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == (PTR_W+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO may still accept.
   assign w_push = push && (!full || w_pop);
   assign head   = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/taxi_axi_wr_sched.sv
// +----------------------------------------------------------------------------+
// | taxi_axi_wr_sched : round-robin AW scheduler, W/B routed in AW grant order  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module taxi_axi_wr_sched
   import taxi_axi_sched_pkg::*;
#(
   parameter int S_COUNT = 4,
   parameter int ISSUE   = 4,
   parameter int W_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [S_COUNT-1:0]           s_aw_valid,
   output logic [S_COUNT-1:0]           s_aw_ready,
   output logic                         m_aw_valid,
   input  logic                         m_aw_ready,
   output logic [$clog2(S_COUNT)-1:0]   aw_sel,
   input  logic [S_COUNT-1:0]           s_w_valid,
   input  logic [S_COUNT-1:0]           s_w_last,
   output logic [S_COUNT-1:0]           s_w_ready,
   output logic                         m_w_valid,
   input  logic                         m_w_ready,
   output logic [$clog2(S_COUNT)-1:0]   w_sel,
   input  logic                         m_b_valid,
   output logic                         m_b_ready,
   output logic [S_COUNT-1:0]           s_b_valid,
   input  logic [S_COUNT-1:0]           s_b_ready,
   output logic [$clog2(S_COUNT)-1:0]   b_sel,
   output logic                         busy
);

   localparam int SEL_W = $clog2(S_COUNT);

   aw_state_t        r_state;
   aw_state_t        w_state_next;
   logic [SEL_W-1:0] r_aw_sel;
   logic [SEL_W-1:0] r_rr;
   logic [SEL_W-1:0] w_pick;
   logic             w_found;
   logic             w_grant;
   logic             w_aw_hs;
   logic             w_wf_full;
   logic             w_wf_empty;
   logic [SEL_W-1:0] w_wf_head;
   logic             w_wf_pop;
   logic             w_bf_full;
   logic             w_bf_empty;
   logic [SEL_W-1:0] w_bf_head;
   logic             w_bf_pop;

   function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= S_COUNT) s = s - S_COUNT;
      return SEL_W'(s);
   endfunction

   // A new grant needs room in both order FIFOs; the B FIFO depth is the issue limit.
   assign w_grant = (|s_aw_valid) && !w_wf_full && !w_bf_full;
   assign w_aw_hs = (r_state == GRANT) && m_aw_ready;

   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (!w_found && s_aw_valid[wrap_add(r_rr, i)]) begin
            w_found = 1'b1;
            w_pick  = wrap_add(r_rr, i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_state_next = GRANT;
         GRANT:   if (m_aw_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      m_aw_valid = 1'b0;
      s_aw_ready = '0;
      if (r_state == GRANT) begin
         m_aw_valid           = 1'b1;
         s_aw_ready[r_aw_sel] = m_aw_ready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aw_sel <= '0;
         r_rr     <= '0;
      end else begin
         if (r_state == IDLE && w_grant) r_aw_sel <= w_pick;
         if (w_aw_hs)                    r_rr     <= wrap_add(r_aw_sel, 1);
      end
   end

   assign aw_sel = r_aw_sel;
   assign busy   = !w_bf_empty || (r_state == GRANT);

   taxi_axi_wr_sched_fifo #(
      .DEPTH (W_DEPTH),
      .WIDTH (SEL_W)
   ) u_w_order (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_aw_hs),
      .push_data (r_aw_sel),
      .pop       (w_wf_pop),
      .full      (w_wf_full),
      .empty     (w_wf_empty),
      .head      (w_wf_head)
   );

   taxi_axi_wr_sched_fifo #(
      .DEPTH (ISSUE),
      .WIDTH (SEL_W)
   ) u_b_order (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_aw_hs),
      .push_data (r_aw_sel),
      .pop       (w_bf_pop),
      .full      (w_bf_full),
      .empty     (w_bf_empty),
      .head      (w_bf_head)
   );

   always_comb begin
      m_w_valid = 1'b0;
      s_w_ready = '0;
      w_wf_pop  = 1'b0;
      if (!w_wf_empty) begin
         m_w_valid            = s_w_valid[w_wf_head];
         s_w_ready[w_wf_head] = m_w_ready;
         w_wf_pop             = s_w_valid[w_wf_head] && m_w_ready && s_w_last[w_wf_head];
      end
   end

   assign w_sel = w_wf_head;

   // With no write outstanding a stray B response is never acknowledged.
   always_comb begin
      m_b_ready = 1'b0;
      s_b_valid = '0;
      w_bf_pop  = 1'b0;
      if (!w_bf_empty) begin
         s_b_valid[w_bf_head] = m_b_valid;
         m_b_ready            = s_b_ready[w_bf_head];
         w_bf_pop             = m_b_valid && s_b_ready[w_bf_head];
      end
   end

   assign b_sel = w_bf_head;

endmodule

`default_nettype wire
